// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator core and its request-side dispatcher:
// floor code width, 7-segment floor codes, FSM state constants and the
// direction-preserving sweep selection helper.
package elevator_pkg;

    localparam int FLOOR_W = 2;

    // 7-segment codes {g,f,e,d,c,b,a}, active-high, as produced by the core's encoder
    localparam logic [6:0] SEG_FLOOR0 = 7'h3F;
    localparam logic [6:0] SEG_FLOOR1 = 7'h06;
    localparam logic [6:0] SEG_FLOOR2 = 7'h5B;
    localparam logic [6:0] SEG_FLOOR3 = 7'h4F;

    // Dispatcher FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_TRAVEL = 2'd1;
    localparam state_t ST_DWELL  = 2'd2;
    localparam state_t ST_FAULT  = 2'd3;

    // Result of a sweep selection: whether anything is pending, the chosen
    // floor, and the direction to continue in (1 = DOWN)
    typedef struct packed {
        logic               valid;
        logic [FLOOR_W-1:0] floor;
        logic               down;
    } sel_t;

    // Pick the next floor: a call at the current floor first, then the
    // nearest call ahead in the current direction, otherwise reverse and
    // take the nearest call behind.
    function automatic sel_t pick_target(input logic [3:0] pend,
                                         input logic [FLOOR_W-1:0] cur,
                                         input logic down);
        sel_t               s;
        logic               have_above;
        logic               have_below;
        logic [FLOOR_W-1:0] above_f;
        logic [FLOOR_W-1:0] below_f;
        s          = '0;
        s.down     = down;
        have_above = 1'b0;
        have_below = 1'b0;
        above_f    = '0;
        below_f    = '0;
        // Descending scan so the last hit is the lowest floor above cur
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && pend[i]) begin
                have_above = 1'b1;
                above_f    = FLOOR_W'(i);
            end
        end
        // Ascending scan so the last hit is the highest floor below cur
        for (int i = 0; i < 4; i++) begin
            if (i < int'(cur) && pend[i]) begin
                have_below = 1'b1;
                below_f    = FLOOR_W'(i);
            end
        end
        s.valid = |pend;
        if (pend[cur]) begin
            s.floor = cur;
        end else if (!down) begin
            if (have_above) begin
                s.floor = above_f;
            end else if (have_below) begin
                s.floor = below_f;
                s.down  = 1'b1;
            end
        end else begin
            if (have_below) begin
                s.floor = below_f;
            end else if (have_above) begin
                s.floor = above_f;
                s.down  = 1'b0;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/seg7_floor_decoder.sv
// Maps the core's 7-segment floor display back to a 2-bit floor number;
// any code that is not one of the four floor glyphs is reported invalid.
module seg7_floor_decoder
    import elevator_pkg::*;
(
    input  logic [6:0]         code_i,
    output logic               valid_o,
    output logic [FLOOR_W-1:0] floor_o
);

    // Pure lookup of the four legal glyphs
    always_comb begin
        valid_o = 1'b1;
        floor_o = '0;
        case (code_i)
            SEG_FLOOR0: floor_o = 2'd0;
            SEG_FLOOR1: floor_o = 2'd1;
            SEG_FLOOR2: floor_o = 2'd2;
            SEG_FLOOR3: floor_o = 2'd3;
            default:    valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/floor_call_dispatcher.sv
// Request-side front end for the elevator core: latches hall calls, picks
// the next target with a direction-preserving sweep, drives the core's
// in/en/stop inputs and confirms arrival from the core's floor display.
module floor_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS     = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int DWELL_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [6:0]            floor_display,
    output logic [FLOOR_W-1:0]    in,
    output logic                  en,
    output logic                  stop,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [3:0]            served_count,
    output logic                  disp_err,
    output logic                  fault
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      in_q, in_d;
    logic                    dir_q, dir_d;          // 1 = sweeping DOWN
    logic [FLOOR_W-1:0]      cur_q, cur_d;          // last validly decoded floor
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [3:0]              served_q, served_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [TW-1:0]           travel_q, travel_d;
    logic [DW-1:0]           dwell_q, dwell_d;

    logic                    dec_valid;
    logic [FLOOR_W-1:0]      dec_floor;
    logic                    match;
    logic                    arrive;
    logic [NUM_FLOORS-1:0]   set_mask;
    sel_t                    sel;

    seg7_floor_decoder u_dec (
        .code_i  (floor_display),
        .valid_o (dec_valid),
        .floor_o (dec_floor)
    );

    // Next-state logic: call latching, sweep selection and the dispatch FSM
    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        dir_d     = dir_q;
        cur_d     = cur_q;
        served_d  = served_q;
        settle_d  = settle_q;
        travel_d  = travel_q;
        dwell_d   = dwell_q;
        arrive    = 1'b0;
        match     = dec_valid && (dec_floor == in_q);
        sel       = pick_target(pending_q, cur_q, dir_q);

        if (dec_valid) begin
            cur_d = dec_floor;
        end

        // Presses at the floor being served are swallowed while the doors are open
        set_mask = call_btn;
        if (state_q == ST_DWELL) begin
            set_mask[in_q] = 1'b0;
        end
        pending_d = pending_q | set_mask;

        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                travel_d = '0;
                dwell_d  = '0;
                if (sel.valid) begin
                    in_d    = sel.floor;
                    dir_d   = sel.down;
                    state_d = ST_TRAVEL;
                end
            end
            ST_TRAVEL: begin
                travel_d = travel_q + TW'(1);
                if (match) begin
                    if (settle_q == SETTLE_LAST) begin
                        arrive   = 1'b1;
                        state_d  = ST_DWELL;
                        dwell_d  = '0;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end else begin
                    settle_d = '0;
                end
                // Arrival takes priority over a coincident timeout
                if (!arrive && travel_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arrive) begin
            pending_d[in_q] = 1'b0;
            served_d        = served_q + 4'd1;
        end
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            in_q      <= '0;
            dir_q     <= 1'b0;
            cur_q     <= '0;
            pending_q <= '0;
            served_q  <= '0;
            settle_q  <= '0;
            travel_q  <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            dir_q     <= dir_d;
            cur_q     <= cur_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            settle_q  <= settle_d;
            travel_q  <= travel_d;
            dwell_q   <= dwell_d;
        end
    end

    // Core-facing controls are decoded straight from the state register
    always_comb begin
        en           = (state_q == ST_TRAVEL) || (state_q == ST_DWELL);
        stop         = (state_q == ST_DWELL) || (state_q == ST_FAULT);
        fault        = (state_q == ST_FAULT);
        in           = in_q;
        pending      = pending_q;
        served_count = served_q;
        disp_err     = rst && !dec_valid;
    end

endmodule
